// File: rtl/sm_dmem_arbiter.sv
// sm_dmem_arbiter: shares one single-port data memory between the CPU data port (master 0)
// and a secondary requester such as a loader or DMA engine (master 1).
//
// Arbitration is fixed priority in favour of master 0. A wait counter forces a grant to
// master 1 once it has waited MAX_WAIT cycles. A granted transfer with lock set keeps
// ownership with that master until it completes a transfer with lock clear. Read data
// returns RD_LAT cycles after the grant and is steered to the owner by a {valid, owner} pipe.
//
// Parameters:
//   AW       address width
//   DW       data width
//   MAX_WAIT cycles master 1 may wait before a forced grant (1..15)
//   RD_LAT   memory read latency in cycles (1..4)
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   mX_req/we/lock/addr/wdata     master X request, write enable, lock, address, write data
//   mX_gnt                        master X accepted this cycle (combinational)
//   mX_rvalid/rdata               read return for master X
//   s_req/we/addr/wdata           memory request side
//   s_rdata                       memory read data, valid RD_LAT cycles after read accept
module sm_dmem_arbiter #(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned RD_LAT   = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic          m0_lock,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          s_req,
  output logic          s_we,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_wdata,
  input  logic [DW-1:0] s_rdata
);

  typedef enum logic [1:0] {StArb, StLock0, StLock1} state_e;

  state_e state_q, state_d;

  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       wait_full;

  // Read-return pipe: stage 0 is the newest entry, stage RD_LAT-1 faces the masters.
  logic [RD_LAT-1:0] pv_q, pv_d;
  logic [RD_LAT-1:0] po_q, po_d;

  assign wait_full = (wait_cnt_q == 4'(MAX_WAIT));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StArb;
      wait_cnt_q <= 4'd0;
      pv_q       <= '0;
      po_q       <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      pv_q       <= pv_d;
      po_q       <= po_d;
    end
  end

  // Next-state logic: ownership only changes on a granted transfer.
  always_comb begin
    state_d = state_q;
    if (m0_gnt) begin
      state_d = m0_lock ? StLock0 : StArb;
    end else if (m1_gnt) begin
      state_d = m1_lock ? StLock1 : StArb;
    end
  end

  // Wait counter keeps running through LOCK0 so master 1 wins as soon as the lock drops.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!m1_req || m1_gnt) begin
      wait_cnt_d = 4'd0;
    end else if (!wait_full) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  // Read-return pipe shift
  always_comb begin
    pv_d    = '0;
    po_d    = '0;
    pv_d[0] = s_req & ~s_we;
    po_d[0] = m1_gnt;
    for (int i = 1; i < int'(RD_LAT); i++) begin
      pv_d[i] = pv_q[i-1];
      po_d[i] = po_q[i-1];
    end
  end

  // Output logic: winner selection and memory-side mux
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    unique case (state_q)
      StLock0: m0_gnt = m0_req;
      StLock1: m1_gnt = m1_req;
      default: begin
        if (m1_req && wait_full) begin
          m1_gnt = 1'b1;
        end else if (m0_req) begin
          m0_gnt = 1'b1;
        end else begin
          m1_gnt = m1_req;
        end
      end
    endcase
    if (rst) begin
      m0_gnt = 1'b0;
      m1_gnt = 1'b0;
    end

    s_req   = m0_gnt | m1_gnt;
    s_we    = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    if (m0_gnt) begin
      s_we    = m0_we;
      s_addr  = m0_addr;
      s_wdata = m0_wdata;
    end else if (m1_gnt) begin
      s_we    = m1_we;
      s_addr  = m1_addr;
      s_wdata = m1_wdata;
    end

    m0_rvalid = pv_q[RD_LAT-1] & ~po_q[RD_LAT-1];
    m1_rvalid = pv_q[RD_LAT-1] & po_q[RD_LAT-1];
    m0_rdata  = s_rdata;
    m1_rdata  = s_rdata;
  end

endmodule

// File: doc/sm_dmem_arbiter.md
# sm_dmem_arbiter

Two-master arbiter sharing the single-port data memory between the CPU data port (master 0) and a secondary requester such as a program loader or debug/DMA engine (master 1). It selects one request per cycle, forwards it to the memory, and routes read data back to the owner after a fixed read latency. Fixed priority favours the CPU. A wait counter forces a grant to master 1 after bounded starvation. A lock mechanism gives either master atomic multi-cycle bursts. It sits between `sm_cpu` (dmAddr/dmWe/dmWData/dmRData) and the data memory; CPU stall logic consumes `m0_gnt`.

## Interface
- `AW`, 32: address width
- `DW`, 32: data width
- `MAX_WAIT`, 4: cycles master 1 may wait before forced grant (1..15)
- `RD_LAT`, 1: memory read latency in cycles (1..4)

- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `m0_req`, `m1_req`  in  1  master request valid
- `m0_we`, `m1_we`  in  1  write enable (1 = write, 0 = read)
- `m0_lock`, `m1_lock`  in  1  keep ownership after this transfer
- `m0_addr`, `m1_addr`  in  AW  word address
- `m0_wdata`, `m1_wdata`  in  DW  write data
- `m0_gnt`, `m1_gnt`  out  1  request accepted this cycle (combinational)
- `m0_rvalid`, `m1_rvalid`  out  1  read data valid for this master
- `m0_rdata`, `m1_rdata`  out  DW  read data (= `s_rdata`, qualified by rvalid)
- `s_req`  out  1  memory access this cycle
- `s_we`  out  1  memory write enable
- `s_addr`  out  AW  memory address
- `s_wdata`  out  DW  memory write data
- `s_rdata`  in  DW  memory read data, valid RD_LAT cycles after read accept

## Operation
- State machine: ARB (free), LOCK0 (owned by m0), LOCK1 (owned by m1).
- ARB winner selection:
  - If `m1_req` and `wait_cnt == MAX_WAIT`, then m1.
  - Else if `m0_req`, then m0.
  - Else if `m1_req`, then m1.
  - Else none.
- LOCK0: only m0 can be granted. m1 is never granted, even if m0 is idle.
- LOCK1: the same rule with the roles swapped.
- Grant: `mX_gnt = winner==X`. `s_req = |gnt`. `s_we`/`s_addr`/`s_wdata` are muxed from the winner. When idle they are zero.
- Transitions are evaluated only on a granted transfer:
  - Granted with `lock = 1` goes to LOCKX.
  - Granted with `lock = 0` goes to ARB.
  - No grant leaves the state unchanged.
- A lock without a following request holds ownership indefinitely. This is a software rule; the arbiter has no timeout.
- wait_cnt is 4 bits:
  - +1 per cycle with `m1_req & ~m1_gnt`, saturating at MAX_WAIT.
  - Cleared on `m1_gnt` or `~m1_req`.
  - It counts during LOCK0 as well, so m1 wins immediately once the lock is released.
- Read return uses a RD_LAT-deep shift pipe of {valid, owner}. Entry is {`s_req & ~s_we`, winner}. At pipe output: `mX_rvalid = valid & owner==X`.
- `m0_rdata` and `m1_rdata` are both driven by `s_rdata` unconditionally.
- Writes produce no rvalid.

## Timing
- Reset (`rst` high at clock edge):
  - State goes to ARB, wait_cnt to 0, pipe valid bits to 0.
  - While `rst` is high, all `gnt` and `s_req` outputs are forced 0.
  - All `rvalid` outputs are 0 on the cycle after the reset edge.
- Reset mid-operation: in-flight reads are discarded and never produce rvalid. Any lock is dropped.
- Grant latency is 0 cycles: a request is accepted in the same cycle it is seen.
- Read data returns exactly RD_LAT cycles after `gnt`.
- Throughput is 1 transfer per cycle with back-to-back reads from either master.
- Pipe entries from different owners may interleave freely. Ordering is preserved per master and globally.
- Same-cycle events:
  - Both masters requesting in ARB: m0 wins unless forced.
  - Grant with `lock = 0` while the other master requests: the other master is eligible on the next cycle under ARB rules.
- When forced, master 1 waits at most MAX_WAIT+1 cycles from first request to grant, absent LOCK0.

## Test plan
- Reset then idle: `rst` 1 for 2 cycles, all requests 0. Required: all `gnt`/`s_req`/`rvalid` 0, state ARB.
- Read latency, RD_LAT=2, m0 read addr 0x10, memory returns 0xCAFE. Required: `m0_gnt` in cycle 0, `s_addr`=0x10 in cycle 0, `m0_rvalid` with 0xCAFE in cycle 2, `m1_rvalid` stays 0.
- Starvation, MAX_WAIT=4, m0 and m1 both requesting continuously. Required: m0 granted cycles 0-3, m1 granted cycle 4, wait_cnt back to 0, m0 granted cycle 5.
- Lock burst: m1 alone issues 3 writes with `lock` = 1, 1, 0 while m0 requests from the second cycle. Required: all 3 writes to m1 with no gap, `m0_gnt` 0 throughout, m0 granted the cycle after the final write.
- Reset mid-read, RD_LAT=3: assert `rst` 1 cycle after m1 read grant. Required: no `m1_rvalid` ever, lock cleared, next m0 request granted immediately after `rst` falls.
